popcount_max_sched: RTL
=======================

// Module: popcount_max_sched
// PURPOSE
// - Sequential max-popcount scheduler: accepts InCnt request vectors of InWdt bits and
//   grants the requester whose vector has the most set bits.
// - Reuses one count_ones instance, time-shared over the requesters (one per cycle),
//   instead of InCnt parallel counters plus a combinational max tree.
// - Sits between request sources and a resource consumer; valid/ack result handshake.
// PARAMETERS
// - InCnt   4  number of requesters (>=2)
// - InWdt   8  width of each request vector
// - CntWdt  4  popcount width, must be >= $clog2(InWdt+1)
// - IdxWdt  (localparam) $clog2(InCnt); width of the index result
// PORTS
// - clk_i    in   1              clock, all state on rising edge
// - rst_i    in   1              reset, synchronous, active-high
// - start_i  in   1              request a scheduling run; accepted when start_i & ready_o
// - vec_i    in   InCnt*InWdt    packed vectors, requester k at [k*InWdt +: InWdt]
// - ready_o  out  1              1 only in IDLE
// - valid_o  out  1              result valid, held until ack_i
// - ack_i    in   1              consumer accepts result; ignored unless valid_o
// - idx_o    out  IdxWdt         granted requester index
// - gnt_o    out  InCnt          one-hot of idx_o, all zero when valid_o=0
// - max_o    out  CntWdt         popcount of granted vector
// - zero_o   out  1              valid_o & (max_o==0): no requester has any bit set
// BEHAVIOUR
// - Reset: state=IDLE; ready_o=1; valid_o=0; idx_o=0; gnt_o=0; max_o=0; zero_o=0;
//   internal pointer, best-count, best-index and captured vectors cleared.
// - FSM IDLE -> SCAN -> HOLD -> IDLE.
// - IDLE: ready_o=1. start_i=1 at edge k: capture vec_i into vec_q, ptr=first index,
//   best_cnt=0, best_idx=first index, go SCAN. vec_i not sampled again until next run.
// - SCAN: ready_o=0. Each cycle count_ones(vec_q[ptr]); if cnt > best_cnt (strict)
//   update best_cnt/best_idx. ptr advances mod InCnt; after InCnt evaluations go HOLD.
// - Latency: accept at edge k -> valid_o=1 after edge k+InCnt+1 (InCnt scan cycles,
//   plus one cycle to register the result). Fixed, data-independent.
// - HOLD: valid_o=1; idx_o/gnt_o/max_o/zero_o stable. ack_i=1 at an edge -> IDLE, valid_o=0,
//   gnt_o=0 after that edge; idx_o/max_o keep last value. No back-to-back accept in the ack cycle.
// - start_i outside IDLE: ignored, no queuing. ack_i outside HOLD: ignored.
// - Ties: the first vector in scan order with the maximal count wins (strict compare).
// - All-zero input: max_o=0, idx_o=first index, zero_o=1, gnt_o still one-hot.
// - Width: count_ones output zero-extended/truncated to CntWdt; CntWdt>=$clog2(InWdt+1)
//   makes this lossless. ptr wraps InCnt-1 -> 0.
// - rst_i mid-SCAN or mid-HOLD: aborts the run, no valid_o pulse, outputs at reset values next cycle.
// CONFIGURATION
// - POPSCHED_RR_TIE_EN defined: round-robin tie-break. Register last_idx (reset InCnt-1)
//   updates to idx_o on each ack. Scan starts at first index = (last_idx+1) mod InCnt,
//   so after reset the first run behaves as fixed priority and repeated ties rotate.
// - POPSCHED_RR_TIE_EN undefined: first index is always 0 (fixed priority, lowest index
//   wins ties); no last_idx register.
// TESTING
// - {AA,0F,FF,00} (req0..3), start -> valid_o after InCnt+1 cycles, idx_o=2, max_o=8, gnt_o=0100.
// - {55,FF,FE,40} -> idx_o=1, max_o=8, gnt_o=0010, zero_o=0.
// - {00,00,00,00} -> idx_o=0, max_o=0, zero_o=1, gnt_o=0001.
// - Tie {0F,F0,33,00} run twice with ack: no macro -> idx_o=0 both; POPSCHED_RR_TIE_EN -> 0 then 1.
// - start_i pulsed during SCAN/HOLD, vec_i changed after accept -> ignored, result unchanged;
//   valid_o held 5 cycles with ack_i=0, drops one cycle after ack_i=1.
// - rst_i asserted 2 cycles into SCAN -> next cycle ready_o=1, valid_o=0, no result emitted;
//   a fresh run afterwards returns the correct result.

Source files
------------

// File: rtl/popcount_max_sched.sv
// Sequential max-popcount scheduler: one shared popcounter scans the requesters one per cycle.
// Optional round-robin tie-break with `define POPSCHED_RR_TIE_EN.
module popcount_max_sched #(
    parameter int InCnt  = 4,
    parameter int InWdt  = 8,
    parameter int CntWdt = 4,
    localparam int IdxWdt = $clog2(InCnt)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [InCnt*InWdt-1:0] vec_i,
    output logic                   ready_o,
    output logic                   valid_o,
    input  logic                   ack_i,
    output logic [IdxWdt-1:0]      idx_o,
    output logic [InCnt-1:0]       gnt_o,
    output logic [CntWdt-1:0]      max_o,
    output logic                   zero_o
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

    localparam int SeqWdt = $clog2(InCnt + 1) + 1;
    localparam logic [IdxWdt-1:0] LastIdx = IdxWdt'(InCnt - 1);
    localparam logic [SeqWdt-1:0] SeqEnd  = SeqWdt'(InCnt);
    localparam logic [InCnt-1:0]  OneHot0 = InCnt'(1);

    state_e                         state_q, state_d;
    logic [InCnt-1:0][InWdt-1:0]    vec_q, vec_d;
    logic [IdxWdt-1:0]              ptr_q, ptr_d;
    logic [IdxWdt-1:0]              best_idx_q, best_idx_d;
    logic [CntWdt-1:0]              best_cnt_q, best_cnt_d;
    logic [SeqWdt-1:0]              seq_q, seq_d;
    logic                           ready_q, ready_d;
    logic                           valid_q, valid_d;
    logic [IdxWdt-1:0]              idx_q, idx_d;
    logic [InCnt-1:0]               gnt_q, gnt_d;
    logic [CntWdt-1:0]              max_q, max_d;
    logic                           zero_q, zero_d;
    logic [IdxWdt-1:0]              first_idx;
    logic [CntWdt-1:0]              cur_cnt;

    function automatic logic [CntWdt-1:0] count_ones(input logic [InWdt-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < InWdt; i++) n += int'(v[i]);
        return CntWdt'(n);
    endfunction

`ifdef POPSCHED_RR_TIE_EN
    logic [IdxWdt-1:0] last_idx_q, last_idx_d;
    // Start just after the last winner so that repeated ties rotate.
    assign first_idx = (last_idx_q == LastIdx) ? '0 : last_idx_q + IdxWdt'(1);
`else
    assign first_idx = '0;
`endif

    // The single popcounter, time-shared over the captured vectors.
    assign cur_cnt = count_ones(vec_q[ptr_q]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        ptr_d      = ptr_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        seq_d      = seq_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        max_d      = max_q;
        zero_d     = zero_q;
`ifdef POPSCHED_RR_TIE_EN
        last_idx_d = last_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    vec_d      = vec_i;
                    ptr_d      = first_idx;
                    best_idx_d = first_idx;
                    best_cnt_d = '0;
                    seq_d      = '0;
                    ready_d    = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (seq_q != SeqEnd) begin
                    // Strict compare: earliest in scan order keeps a tie.
                    if (cur_cnt > best_cnt_q) begin
                        best_cnt_d = cur_cnt;
                        best_idx_d = ptr_q;
                    end
                    ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + IdxWdt'(1);
                    seq_d = seq_q + SeqWdt'(1);
                end else begin
                    valid_d = 1'b1;
                    idx_d   = best_idx_q;
                    gnt_d   = OneHot0 << best_idx_q;
                    max_d   = best_cnt_q;
                    zero_d  = (best_cnt_q == '0);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack_i) begin
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    zero_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef POPSCHED_RR_TIE_EN
                    last_idx_d = idx_q;
`endif
                end
            end
            default: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                gnt_d   = '0;
                zero_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            ptr_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            seq_q      <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            gnt_q      <= '0;
            max_q      <= '0;
            zero_q     <= 1'b0;
`ifdef POPSCHED_RR_TIE_EN
            last_idx_q <= LastIdx;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            ptr_q      <= ptr_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            seq_q      <= seq_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
            max_q      <= max_d;
            zero_q     <= zero_d;
`ifdef POPSCHED_RR_TIE_EN
            last_idx_q <= last_idx_d;
`endif
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign gnt_o   = gnt_q;
    assign max_o   = max_q;
    assign zero_o  = zero_q;

endmodule
